// File: rtl/clock_pkg.sv
// Shared wall-clock definitions: button FSM state type and default timing
// constants used by the clock top and its testbench.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } btn_state_t;

  localparam int unsigned DEF_N_BUTTONS       = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;  // 20 ms at 100 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000; // 500 ms
  localparam int unsigned DEF_REPEAT_RATE     = 10_000_000; // 100 ms
  localparam int unsigned DEF_REPEAT_EN       = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchroniser, debouncer and
// press/release/auto-repeat FSM with registered one-cycle pulses.
module button_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic CLK100MHZ,
  input  logic res,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic          sync1, sync2;
  logic          stable, stable_next;
  logic [DW-1:0] deb_cnt, deb_cnt_next;
  logic [RW-1:0] rpt_cnt, rpt_cnt_next;
  btn_state_t    state, state_next;
  logic          press_next, release_next;
  logic          mismatch, flip, rise, fall;

  always_comb begin
    mismatch     = (sync2 != stable);
    flip         = mismatch && (deb_cnt == DEB_LAST);
    rise         = flip && !stable;
    fall         = flip && stable;
    stable_next  = flip ? ~stable : stable;
    deb_cnt_next = (mismatch && !flip) ? deb_cnt + DW'(1) : '0;
  end

  // FSM reacts to the flip decided this cycle so pulses align with btn_level.
  always_comb begin
    state_next   = state;
    rpt_cnt_next = rpt_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    if (fall) begin
      release_next = 1'b1;
      rpt_cnt_next = '0;
      state_next   = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            press_next   = 1'b1;
            rpt_cnt_next = '0;
            state_next   = HOLD;
          end
        end
        HOLD: begin
          if (rpt_cnt == DELAY_LAST) begin
            if (REPEAT_EN != 0) begin
              press_next   = 1'b1;
              rpt_cnt_next = '0;
              state_next   = REPEAT;
            end
          end else begin
            rpt_cnt_next = rpt_cnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt == RATE_LAST) begin
            press_next   = 1'b1;
            rpt_cnt_next = '0;
          end else begin
            rpt_cnt_next = rpt_cnt + RW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge res) begin
    if (res) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      deb_cnt     <= '0;
      rpt_cnt     <= '0;
      state       <= IDLE;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      stable      <= stable_next;
      deb_cnt     <= deb_cnt_next;
      rpt_cnt     <= rpt_cnt_next;
      state       <= state_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

  assign btn_level = stable;

endmodule

// File: rtl/button_conditioner.sv
// Wall-clock button front end: N_BUTTONS independent conditioned channels.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = DEF_N_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic                 CLK100MHZ,
  input  logic                 res,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_EN)
    ) u_ch (
      .CLK100MHZ   (CLK100MHZ),
      .res         (res),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulses are queued with
// their cycle number when stimulus is driven and matched by a monitor.
module tb_button_conditioner;
  import clock_pkg::*;

  localparam int unsigned NB = 2;
  localparam int unsigned DB = 8;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;

  logic CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  logic          res;
  logic [NB-1:0] raw_a, lvl_a, prs_a, rel_a;
  logic [NB-1:0] raw_b, lvl_b, prs_b, rel_b;

  button_conditioner #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .REPEAT_EN(1)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .res(res), .btn_raw(raw_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a)
  );

  button_conditioner #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .REPEAT_EN(0)
  ) dut_nr (
    .CLK100MHZ(CLK100MHZ), .res(res), .btn_raw(raw_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
  );

  typedef struct {
    int unsigned t;
    int unsigned inst;
    int unsigned ch;
    bit          rel;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  // Monitor: every observed pulse must match a queued event for this cycle,
  // and every event that has come due must have been observed.
  always @(negedge CLK100MHZ) begin
    bit v;
    bit found;
    for (int unsigned inst = 0; inst < 2; inst++) begin
      for (int unsigned ch = 0; ch < NB; ch++) begin
        for (int unsigned k = 0; k < 2; k++) begin
          if (inst == 0) v = (k != 0) ? rel_a[ch] : prs_a[ch];
          else           v = (k != 0) ? rel_b[ch] : prs_b[ch];
          if (v) begin
            found = 1'b0;
            for (int i = 0; i < sb.size(); i++) begin
              if (!found && sb[i].t == cyc && sb[i].inst == inst &&
                  sb[i].ch == ch && sb[i].rel == (k != 0)) begin
                sb.delete(i);
                found = 1'b1;
                break;
              end
            end
            n_checks++;
            if (!found) begin
              n_fail++;
              $display("FAIL unexpected_pulse inst=%0d ch=%0d %s at cycle %0d: got 1, required 0",
                       inst, ch, (k != 0) ? "release" : "press", cyc);
            end
          end
        end
      end
    end
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].t <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse inst=%0d ch=%0d %s due cycle %0d: got 0, required 1",
                 sb[i].inst, sb[i].ch, sb[i].rel ? "release" : "press", sb[i].t);
        sb.delete(i);
      end
    end
  end

  task automatic push_ev(input int unsigned t, input int unsigned inst,
                         input int unsigned ch, input bit rel);
    ev_t e;
    e.t = t; e.inst = inst; e.ch = ch; e.rel = rel;
    sb.push_back(e);
  endtask

  // Reference timing for a clean hold whose first high sample is edge t0.
  task automatic push_hold(input int unsigned inst, input int unsigned ch,
                           input int unsigned t0, input int unsigned hold,
                           input bit en);
    int unsigned p, r;
    p = t0 + DB + 1;
    r = t0 + hold + DB + 1;
    push_ev(p, inst, ch, 1'b0);
    if (en) begin
      p = p + RD;
      while (p < r) begin
        push_ev(p, inst, ch, 1'b0);
        p = p + RR;
      end
    end
    push_ev(r, inst, ch, 1'b1);
  endtask

  task automatic drive_hold(input int unsigned inst, input logic [NB-1:0] mask,
                            input int unsigned hold, input bit en,
                            output int unsigned t0);
    @(negedge CLK100MHZ);
    t0 = cyc + 1;
    if (inst == 0) raw_a = mask; else raw_b = mask;
    for (int unsigned ch = 0; ch < NB; ch++)
      if (mask[ch]) push_hold(inst, ch, t0, hold, en);
    repeat (hold) @(negedge CLK100MHZ);
    if (inst == 0) raw_a = '0; else raw_b = '0;
  endtask

  task automatic test_reset;
    res = 1'b1; raw_a = '0; raw_b = '0;
    repeat (3) @(negedge CLK100MHZ);
    n_checks++;
    if ({lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0",
               {lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b});
    end
    res = 1'b0;
    repeat (DB + 6) @(negedge CLK100MHZ);
    n_checks++;
    if ({lvl_a, lvl_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_low_idle: got %b, required 0", {lvl_a, lvl_b});
    end
  endtask

  task automatic test_clean;
    int unsigned t0;
    drive_hold(0, 2'b01, 12, 1'b1, t0);
    repeat (4) @(negedge CLK100MHZ);
    n_checks++;
    if (lvl_a !== 2'b01) begin
      n_fail++;
      $display("FAIL clean_level at cycle %0d: got %b, required 01", cyc, lvl_a);
    end
    repeat (20) @(negedge CLK100MHZ);
    n_checks++;
    if (lvl_a !== 2'b00 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL clean_done: level %b pending %0d, required 00 and 0", lvl_a, sb.size());
    end
  endtask

  task automatic test_bounce;
    int unsigned seen;
    int unsigned seg[4];
    seen = 0;
    seg[0] = 5; seg[1] = 2; seg[2] = 5; seg[3] = DB + 12;
    for (int unsigned s = 0; s < 4; s++) begin
      @(negedge CLK100MHZ);
      raw_a[0] = (s == 0 || s == 2);
      for (int unsigned c = 0; c < seg[s]; c++) begin
        @(negedge CLK100MHZ);
        if (lvl_a[0] || prs_a[0]) seen++;
      end
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL bounce_rejected: got %0d active cycles, required 0", seen);
    end
  endtask

  // 55-cycle hold puts the release on the same edge as a repeat expiry.
  task automatic test_repeat;
    int unsigned t0;
    drive_hold(0, 2'b10, 55, 1'b1, t0);
    n_checks++;
    if (lvl_a !== 2'b10) begin
      n_fail++;
      $display("FAIL repeat_level: got %b, required 10", lvl_a);
    end
    repeat (DB + 6) @(negedge CLK100MHZ);
    n_checks++;
    if (sb.size() != 0 || lvl_a !== 2'b00) begin
      n_fail++;
      $display("FAIL repeat_done: pending %0d level %b, required 0 and 00", sb.size(), lvl_a);
    end
  endtask

  task automatic test_no_repeat;
    int unsigned t0;
    drive_hold(1, 2'b01, 100, 1'b0, t0);
    n_checks++;
    if (lvl_b !== 2'b01) begin
      n_fail++;
      $display("FAIL norepeat_level: got %b, required 01", lvl_b);
    end
    repeat (DB + 6) @(negedge CLK100MHZ);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL norepeat_done: pending %0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    int unsigned t0, c;
    @(negedge CLK100MHZ);
    t0 = cyc + 1;
    raw_a[0] = 1'b1;
    push_ev(t0 + DB + 1, 0, 0, 1'b0);
    while (cyc < t0 + 14) @(negedge CLK100MHZ);
    n_checks++;
    if (lvl_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midhold_level: got %b, required 1", lvl_a[0]);
    end
    #1 res = 1'b1;
    #1;
    n_checks++;
    if ({lvl_a, prs_a, rel_a} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b, required 0", {lvl_a, prs_a, rel_a});
    end
    repeat (3) @(negedge CLK100MHZ);
    c = cyc;
    res = 1'b0;
    push_ev(c + DB + 2, 0, 0, 1'b0);
    push_ev(c + 13 + DB + 1, 0, 0, 1'b1);
    while (cyc < c + 12) @(negedge CLK100MHZ);
    raw_a[0] = 1'b0;
    repeat (DB + 10) @(negedge CLK100MHZ);
    n_checks++;
    if (sb.size() != 0 || lvl_a !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_repress_done: pending %0d level %b, required 0 and 00", sb.size(), lvl_a);
    end
  endtask

  task automatic test_both;
    int unsigned t0;
    drive_hold(0, 2'b11, 40, 1'b1, t0);
    n_checks++;
    if (lvl_a !== 2'b11) begin
      n_fail++;
      $display("FAIL both_level: got %b, required 11", lvl_a);
    end
    repeat (DB + 6) @(negedge CLK100MHZ);
    n_checks++;
    if (sb.size() != 0 || lvl_a !== 2'b00) begin
      n_fail++;
      $display("FAIL both_done: pending %0d level %b, required 0 and 00", sb.size(), lvl_a);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_reset_mid_hold();
    test_both();
    repeat (4) @(negedge CLK100MHZ);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
